// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - pipelined binary decoder with mode select, range check and skid buffer
// Optional error counter (err_clr/err_cnt ports) enabled by DECODER_PIPE_ERR_CNT_EN.
module decoder_pipe #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_err
`ifdef DECODER_PIPE_ERR_CNT_EN
    ,
    input  logic             err_clr,
    output logic [7:0]       err_cnt
`endif
);

    logic [OUT_W-1:0] dec_y;
    logic             dec_err;
    logic [31:0]      k;

    logic             skid_valid;
    logic [OUT_W-1:0] skid_y;
    logic             skid_err;

    logic             accept;
    logic             drain;

    always_comb begin
        dec_y   = '0;
        dec_err = 1'b0;
        k       = 32'(in_a);
        if (in_mode == 2'b11 || k >= 32'(OUT_W)) begin
            dec_err = 1'b1;
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                case (in_mode)
                    2'b00:   dec_y[i] = (k == 32'(i));
                    2'b01:   dec_y[i] = (32'(i) <= k);
                    default: dec_y[i] = (k != 32'(i));
                endcase
            end
        end
    end

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_y     <= '0;
            skid_err   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Output stage free this cycle: skid has priority to keep FIFO order.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_y      <= skid_y;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_y     <= dec_y;
                out_err   <= dec_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_y     <= dec_y;
            skid_err   <= dec_err;
        end
    end

`ifdef DECODER_PIPE_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (err_clr) begin
            err_cnt <= 8'h00;
        end else if (drain && out_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`else
    logic unused_drain;
    assign unused_drain = drain;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - scoreboard bench for decoder_pipe (OUT_W=8 and OUT_W=6 instances)
module tb_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0] in_a;
    logic [1:0] in_mode;
    logic [7:0] out_y;

    logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b;
    logic [2:0] in_a_b;
    logic [1:0] in_mode_b;
    logic [5:0] out_y_b;

`ifdef DECODER_PIPE_ERR_CNT_EN
    logic       err_clr, err_clr_b;
    logic [7:0] err_cnt, err_cnt_b;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] e1, e2;

    always #5 clk = ~clk;

    decoder_pipe #(.IN_W(3), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err)
`ifdef DECODER_PIPE_ERR_CNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

    decoder_pipe #(.IN_W(3), .OUT_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_a(in_a_b), .in_mode(in_mode_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b), .out_err(out_err_b)
`ifdef DECODER_PIPE_ERR_CNT_EN
        , .err_clr(err_clr_b), .err_cnt(err_cnt_b)
`endif
    );

    function automatic logic [8:0] model(input int a, input int m, input int w);
        int y;
        int mask;
        mask = (1 << w) - 1;
        if (m == 3 || a >= w) return 9'h100;
        case (m)
            0:       y = 1 << a;
            1:       y = (2 << a) - 1;
            default: y = ~(1 << a);
        endcase
        return {1'b0, 8'(y & mask)};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL out8_unexpected got err=%b y=%h, wanted no output", out_err, out_y);
            end else begin
                e1 = q1.pop_front();
                if ({out_err, out_y} !== e1) begin
                    miscompares++;
                    $display("FAIL out8_data got err=%b y=%h, wanted err=%b y=%h", out_err, out_y, e1[8], e1[7:0]);
                end
            end
        end
        if (rst_n === 1'b1 && out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
            vectors++;
            if (q2.size() == 0) begin
                miscompares++;
                $display("FAIL out6_unexpected got err=%b y=%h, wanted no output", out_err_b, out_y_b);
            end else begin
                e2 = q2.pop_front();
                if ({out_err_b, 2'b00, out_y_b} !== e2) begin
                    miscompares++;
                    $display("FAIL out6_data got err=%b y=%h, wanted err=%b y=%h", out_err_b, out_y_b, e2[8], e2[5:0]);
                end
            end
        end
    end

    task automatic put(input logic [2:0] a, input logic [1:0] m);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_mode = m;
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL put_timeout a=%0d in_ready=%b, wanted 1", a, in_ready);
        end else begin
            q1.push_back(model(int'(a), int'(m), 8));
        end
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 64 && q1.size() != 0; c++) @(posedge clk);
        #1;
        vectors++;
        if (q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout pending=%0d, wanted 0", q1.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_mode = '0; out_ready = 1'b0;
        in_valid_b = 1'b0; in_a_b = '0; in_mode_b = '0; out_ready_b = 1'b0;
`ifdef DECODER_PIPE_ERR_CNT_EN
        err_clr = 1'b0; err_clr_b = 1'b0;
`endif
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got v=%b y=%h e=%b r=%b, wanted 0 00 0 1", out_valid, out_y, out_err, in_ready);
        end
`ifdef DECODER_PIPE_ERR_CNT_EN
        vectors++;
        if (err_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_err_cnt got %h, wanted 00", err_cnt);
        end
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_onehot();
        out_ready = 1'b1;
        for (int a = 0; a < 8; a++) begin
            put(3'(a), 2'b00);
            vectors++;
            if (out_valid !== 1'b1 || out_y !== 8'(1 << a)) begin
                miscompares++;
                $display("FAIL onehot_latency a=%0d got v=%b y=%h, wanted 1 %h", a, out_valid, out_y, 8'(1 << a));
            end
        end
        drain();
    endtask

    task automatic test_thermo();
        out_ready = 1'b1;
        put(3'd0, 2'b01);
        put(3'd3, 2'b01);
        vectors++;
        if (out_y !== 8'h0F) begin
            miscompares++;
            $display("FAIL thermo_3 got %h, wanted 0F", out_y);
        end
        put(3'd7, 2'b01);
        put(3'd2, 2'b10);
        vectors++;
        if (out_y !== 8'hFB) begin
            miscompares++;
            $display("FAIL activelow_2 got %h, wanted FB", out_y);
        end
        put(3'd5, 2'b10);
        put(3'd6, 2'b11);
        drain();
    endtask

    task automatic test_range();
        logic [2:0] av[6] = '{3'd6, 3'd7, 3'd1, 3'd5, 3'd5, 3'd0};
        logic [1:0] mv[6] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
        out_ready_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid_b = 1'b1;
            in_a_b = av[i];
            in_mode_b = mv[i];
            @(posedge clk);
            q2.push_back(model(int'(av[i]), int'(mv[i]), 6));
            #1;
            vectors++;
            if (out_valid_b !== 1'b1) begin
                miscompares++;
                $display("FAIL range_valid i=%0d got %b, wanted 1", i, out_valid_b);
            end
        end
        in_valid_b = 1'b0;
        for (int c = 0; c < 16 && q2.size() != 0; c++) @(posedge clk);
        #1;
        vectors++;
        if (q2.size() != 0) begin
            miscompares++;
            $display("FAIL range_drain pending=%0d, wanted 0", q2.size());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        put(3'd1, 2'b00);
        put(3'd4, 2'b00);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_in_ready got %b, wanted 0", in_ready);
        end
        in_valid = 1'b1; in_a = 3'd6; in_mode = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_y !== 8'h02 || out_err !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stall c=%0d got v=%b y=%h e=%b r=%b, wanted 1 02 0 0", c, out_valid, out_y, out_err, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        put(3'd6, 2'b00);
        drain();
    endtask

    task automatic test_back_to_back_random();
        bit acc;
        int sent;
        sent = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 2000 && sent < 150; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                q1.push_back(model(int'(in_a), int'(in_mode), 8));
                sent++;
            end
            #1;
            out_ready = 1'($urandom_range(0, 1));
            if (acc || !in_valid) begin
                in_valid = (sent < 150) && ($urandom_range(0, 3) != 0);
                in_a = 3'($urandom_range(0, 7));
                in_mode = 2'($urandom_range(0, 3));
            end
        end
        vectors++;
        if (sent != 150) begin
            miscompares++;
            $display("FAIL random_sent got %0d, wanted 150", sent);
        end
        drain();
    endtask

`ifdef DECODER_PIPE_ERR_CNT_EN
    task automatic test_err_cnt();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) put(3'd1, 2'b11);
        drain();
        vectors++;
        if (err_cnt !== 8'hFF) begin
            miscompares++;
            $display("FAIL err_cnt_sat got %h, wanted FF", err_cnt);
        end
        out_ready = 1'b0;
        put(3'd0, 2'b11);
        err_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        vectors++;
        if (err_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL err_cnt_clr got %h, wanted 00", err_cnt);
        end
        drain();
    endtask
`endif

    task automatic test_reset_mid();
        out_ready = 1'b0;
        put(3'd2, 2'b00);
        put(3'd3, 2'b01);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid got v=%b y=%h e=%b r=%b, wanted 0 00 0 1", out_valid, out_y, out_err, in_ready);
        end
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_stale c=%0d got v=%b r=%b, wanted 0 1", c, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_thermo();
        test_range();
        test_backpressure();
        test_back_to_back_random();
`ifdef DECODER_PIPE_ERR_CNT_EN
        test_err_cnt();
`endif
        test_reset_mid();
        vectors++;
        if (q1.size() != 0 || q2.size() != 0) begin
            miscompares++;
            $display("FAIL leftover got %0d/%0d pending, wanted 0/0", q1.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
Parametrised, pipelined binary decoder. Generalises the fixed 3-to-8 one-hot decoder to IN_W-bit inputs and OUT_W-bit outputs. Adds per-transaction mode select (one-hot, thermometer, active-low one-hot), out-of-range detection and valid/ready flow control with a skid buffer. It sits between an address/select producer and downstream enable fabric, such as bank selects or lane enables, that can apply backpressure.

Parameters:
IN_W, 3, width of binary input code (1..8)
OUT_W, 8, output width; legal range 2..2**IN_W; codes >= OUT_W are out of range

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
in_a  input  IN_W  binary code to decode
in_mode  input  2  00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved
out_valid  output  1  output transaction valid
out_ready  input  1  downstream accepts output this cycle
out_y  output  OUT_W  decoded vector
out_err  output  1  transaction was out-of-range or used reserved mode

Behaviour:
- Reset (async assert, sync release on clk): out_valid=0, out_y=0, out_err=0, in_ready=1, skid buffer empty.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid must not depend on in_ready.
- Latency: 1 cycle. A transfer accepted at edge N appears on out_y/out_err with out_valid=1 after edge N, when the output stage is free.
- Structure: one output register stage plus one skid register.
  - in_ready = !skid_valid, a registered signal with no combinational path from out_ready.
- Datapath: decode is combinational from in_a/in_mode, registered on accept. With k = in_a:
  - 00: out_y[k]=1, all other bits 0.
  - 01: out_y[i]=1 for all i<=k, so k=0 gives 0x01 and k=3 gives 0x0F.
  - 10: bitwise inverse of the mode-00 result.
  - 11: out_y=0, out_err=1.
  - k >= OUT_W in any mode: out_y=0 (all zeros, including mode 10), out_err=1.
  - Otherwise out_err=0.
- Flow control:
  - Output stage empty, or draining this cycle (out_ready=1): an accepted input loads the output stage directly.
  - Output stage full and out_ready=0: an accepted input loads the skid register, and in_ready drops next cycle.
  - When the output drains and the skid register is valid, skid contents move to the output stage and in_ready rises next cycle.
- Ordering: strict FIFO, no drop, no duplication. At most 2 transactions in flight.
- Stall: while out_valid=1 and out_ready=0, out_y/out_err hold stable.
- Simultaneous accept and drain with the skid register empty: the new data replaces the output register, and out_valid stays 1.
- Throughput: full throughput (1 transfer/cycle) while out_ready stays high.
- Reset mid-operation: both stages flush immediately with no output transfer. Transactions in flight are lost by design.
- X/unknown in_a while in_valid=0 must not affect state.

Optional Feature:
Macro DECODER_PIPE_ERR_CNT_EN.
- Defined: adds output port err_cnt [7:0].
  - Increments on every output transfer with out_err=1.
  - Saturates at 8'hFF and resets to 0.
  - Also clears synchronously when input port err_clr (1 bit) is high. Clear takes priority over a same-cycle increment.
- Undefined: neither port exists, no counter logic is synthesised, and all other behaviour is identical.

Test Plan:
1. IN_W=3, OUT_W=8, mode 00, sweep in_a 0..7 with out_ready=1 -> out_y 0x01,0x02,...,0x80 one cycle after each accept, out_err=0, back-to-back out_valid.
2. Mode 01, in_a=0,3,7 -> out_y 0x01,0x0F,0xFF. Mode 10, in_a=2 -> out_y 0xFB.
3. IN_W=3, OUT_W=6, in_a=6 mode 00 -> out_y=0x00, out_err=1. Then in_mode=11 with in_a=1 -> out_y=0x00, out_err=1.
4. Backpressure:
   - Steps: hold out_ready=0 and offer 3 transactions A,B,C.
   - A and B are accepted; in_ready=0 the cycle after B is accepted, and C waits.
   - Raise out_ready -> outputs A,B,C in order, none lost or duplicated, out_y stable while stalled.
5. Assert rst_n=0 asynchronously with 2 transactions buffered -> out_valid=0, out_y=0, in_ready=1 immediately. No stale output after release.
6. With DECODER_PIPE_ERR_CNT_EN:
   - 300 error transfers -> err_cnt=0xFF.
   - err_clr coincident with an error transfer -> err_cnt=0x00.
